// File: rtl/instruction_fetch.sv
// instruction_fetch: PC-driven fetch from a 1-cycle synchronous ROM into a small
// tagged FIFO with a valid/ready handoff to decode and branch/jump redirect flush.
// Optional: define FETCH_COUNT_EN to add the fetch_count output (pops since reset).
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          DEPTH        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_data,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]           fetch_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic          r_kill;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic [31:0]   r_last_instr;
  logic [31:0]   r_last_pc;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;

  // Handshake, issue decision and head presentation; an in-flight read counts as
  // an occupied slot so a returning word always has room and is never dropped.
  always_comb begin
    instr_valid = r_count != '0;
    w_pop       = instr_valid && instr_ready && !redirect_valid;
    w_push      = r_inflight && !r_kill && !redirect_valid;
    w_occ       = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    w_issue     = !redirect_valid && (w_occ < (CW+1)'(DEPTH));
    instr       = instr_valid ? r_fifo_instr[r_rp] : r_last_instr;
    instr_pc    = instr_valid ? r_fifo_pc[r_rp] : r_last_pc;
    mem_address = r_fetch_pc[ADDR_WIDTH-1:0];
  end

  // Fetch PC, outstanding-request tag and kill of a read that straddles a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_VECTOR;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= redirect_valid && r_inflight;
      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  // Instruction FIFO; a redirect empties it and overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else if (redirect_valid) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wp] <= mem_data;
        r_fifo_pc[r_wp]    <= r_req_pc;
        r_wp               <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp         <= r_rp + PW'(1);
        r_last_instr <= r_fifo_instr[r_rp];
        r_last_pc    <= r_fifo_pc[r_rp];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef FETCH_COUNT_EN
  // Count of instructions handed to decode; wraps naturally and ignores redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fetch_count <= '0;
    else if (w_pop)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized ready/redirect traffic
// checked against a program-order stream model of the fetch stage.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  mem_address;
  logic [31:0] mem_data = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + {24'd0, a[9:2]};
  endfunction

  always @(posedge clk) mem_data <= rom({22'd0, mem_address});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, rom(pc));
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          since;
    #2 reset = 1'b0;
    step;
    step;
    sample;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
`ifdef FETCH_COUNT_EN
    check("rst_count", fetch_count, 32'd0);
`endif
    step;
    reset = 1'b1;
    sample;
    check("lat_c0", 32'(instr_valid), 32'd0);
    step;
    sample;
    check("lat_c1", 32'(instr_valid), 32'd0);
    check("lat_addr", 32'(mem_address), 32'd4);
    step;
    for (int k = 0; k < 8; k++) begin
      sample;
      expect_head("stream", 32'(4 * k));
      step;
    end

    reset = 1'b0;
    instr_ready = 1'b0;
    step;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sample;
      if (k == 9) begin
        check("stall_addr", 32'(mem_address), 32'd8);
        expect_head("stall_head", 32'd0);
      end
      step;
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample;
      expect_head("resume", 32'(4 * k));
      step;
    end

    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    sample;
    step;
    redirect_valid = 1'b0;
    sample;
    check("redir_t1", 32'(instr_valid), 32'd0);
    step;
    sample;
    check("redir_t2", 32'(instr_valid), 32'd0);
    step;
    sample;
    expect_head("redir_t3", 32'h100);
    step;
    sample;
    expect_head("redir_t4", 32'h104);
    step;

    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    sample;
    step;
    redirect_pc = 32'h80;
    sample;
    check("b2b_t1", 32'(instr_valid), 32'd0);
    step;
    redirect_valid = 1'b0;
    sample;
    check("b2b_t2", 32'(instr_valid), 32'd0);
    step;
    sample;
    check("b2b_t3", 32'(instr_valid), 32'd0);
    step;
    sample;
    expect_head("b2b_t4", 32'h80);
    step;
    sample;
    expect_head("b2b_t5", 32'h84);
    step;

    redirect_valid = 1'b1;
    redirect_pc = 32'h3FC;
    sample;
    step;
    redirect_valid = 1'b0;
    sample;
    check("wrap_addr_a", 32'(mem_address), 32'h3FC);
    step;
    sample;
    check("wrap_addr_b", 32'(mem_address), 32'h000);
    step;
    sample;
    expect_head("wrap_a", 32'h3FC);
    step;
    sample;
    expect_head("wrap_b", 32'h400);
    check("wrap_word", instr, 32'h1000_0000);
    step;

    since = 1000;
    exp_pc = '0;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] rp;
      rd = (i == 0) || ($urandom_range(0, 19) == 0);
      rp = $urandom;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = rd;
      redirect_pc = rp;
      sample;
      if (rd) begin
        since = 0;
        exp_pc = rp & ~32'h3;
      end else begin
        if (since < 1000) since++;
        if (since == 1 || since == 2) check("rnd_gap", 32'(instr_valid), 32'd0);
        if (since == 3) check("rnd_lat", 32'(instr_valid), 32'd1);
        if (instr_valid && instr_ready) begin
          check("rnd_pc", instr_pc, exp_pc);
          check("rnd_instr", instr, rom(exp_pc));
          exp_pc += 32'd4;
        end
      end
      step;
    end
    redirect_valid = 1'b0;

    reset = 1'b0;
    instr_ready = 1'b1;
    step;
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      sample;
      step;
    end
    instr_ready = 1'b0;
    sample;
    check("mid_pre_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_COUNT_EN
    check("mid_count5", fetch_count, 32'd5);
`endif
    #1 reset = 1'b0;
    #1;
    check("mid_valid", 32'(instr_valid), 32'd0);
    check("mid_instr", instr, 32'd0);
    check("mid_pc", instr_pc, 32'd0);
    check("mid_addr", 32'(mem_address), 32'd0);
`ifdef FETCH_COUNT_EN
    check("mid_count0", fetch_count, 32'd0);
`endif
    step;
    step;
    sample;
    check("mid_hold_valid", 32'(instr_valid), 32'd0);
    step;
    reset = 1'b1;
    instr_ready = 1'b1;
    sample;
    check("rest_c0", 32'(instr_valid), 32'd0);
    step;
    sample;
    check("rest_c1", 32'(instr_valid), 32'd0);
    step;
    sample;
    expect_head("rest_c2", 32'd0);
    step;
    sample;
    expect_head("rest_c3", 32'd4);
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
